// File: rtl/hack_vga_pkg.sv
// Shared constants for the Hack screen VGA scan-out: 640x480@60 timing,
// the centred 512x256 window and screen RAM geometry.
package hack_vga_pkg;

    localparam int unsigned DEF_H_VIS  = 640;
    localparam int unsigned DEF_H_FP   = 16;
    localparam int unsigned DEF_H_SYNC = 96;
    localparam int unsigned DEF_H_BP   = 48;
    localparam int unsigned DEF_H_TOTAL      = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_H_SYNC_START = DEF_H_VIS + DEF_H_FP;
    localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;

    localparam int unsigned DEF_V_VIS  = 480;
    localparam int unsigned DEF_V_FP   = 10;
    localparam int unsigned DEF_V_SYNC = 2;
    localparam int unsigned DEF_V_BP   = 33;
    localparam int unsigned DEF_V_TOTAL      = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned DEF_V_SYNC_START = DEF_V_VIS + DEF_V_FP;
    localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    localparam int unsigned DEF_WIN_X0 = 64;
    localparam int unsigned DEF_WIN_Y0 = 112;
    localparam int unsigned DEF_WIN_W  = 512;
    localparam int unsigned DEF_WIN_H  = 256;

    localparam int unsigned SCREEN_WORDS  = 8192;
    localparam int unsigned WORDS_PER_ROW = 32;
    localparam int unsigned ADDR_W        = $clog2(SCREEN_WORDS);
    localparam int unsigned WORD_W        = 16;
    localparam int unsigned CNT_W         = 10;

    // Address goes out 8 pixels ahead of a group, data is captured 4 pixels ahead.
    localparam int unsigned FETCH_LEAD = 8;
    localparam int unsigned LATCH_LEAD = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic logic in_range(input cnt_t x, input cnt_t lo, input cnt_t hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/hack_vga_scanout_sync.sv
// Pixel-enable toggle, h/v raster counters and registered sync/video/frame
// decode; every output lags the counter position by exactly one pixel.
module vga_sync_counter
    import hack_vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE    = DEF_H_VIS,
    parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
    parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
    parameter int unsigned H_SYNC_END   = DEF_H_SYNC_END,
    parameter int unsigned V_VISIBLE    = DEF_V_VIS,
    parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
    parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
    parameter int unsigned V_SYNC_END   = DEF_V_SYNC_END
) (
    input  logic clk50_i,
    input  logic rst_i,
    output logic tick_o,
    output cnt_t h_o,
    output cnt_t v_o,
    output logic hsync_o,
    output logic vsync_o,
    output logic video_on_o,
    output logic frame_start_o
);

    localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VEND  = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VEND  = cnt_t'(V_VISIBLE);
    localparam cnt_t HS_LO   = cnt_t'(H_SYNC_START);
    localparam cnt_t HS_HI   = cnt_t'(H_SYNC_END);
    localparam cnt_t VS_LO   = cnt_t'(V_SYNC_START);
    localparam cnt_t VS_HI   = cnt_t'(V_SYNC_END);

    logic toggle_q, toggle_d;
    cnt_t h_q, h_d;
    cnt_t v_q, v_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic video_q, video_d;
    logic fstart_q, fstart_d;

    always_ff @(posedge clk50_i) begin
        if (rst_i) begin
            toggle_q <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            video_q  <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            video_q  <= video_d;
            fstart_q <= fstart_d;
        end
    end

    always_comb begin
        toggle_d = ~toggle_q;
        h_d      = h_q;
        v_d      = v_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        video_d  = video_q;
        fstart_d = 1'b0;
        if (toggle_q) begin
            hsync_d = !in_range(h_q, HS_LO, HS_HI);
            vsync_d = !in_range(v_q, VS_LO, VS_HI);
            video_d = (h_q < H_VEND) && (v_q < V_VEND);
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d      = '0;
                    fstart_d = 1'b1;
                end else begin
                    v_d = v_q + cnt_t'(1);
                end
            end else begin
                h_d = h_q + cnt_t'(1);
            end
        end
    end

    assign tick_o        = toggle_q;
    assign h_o           = h_q;
    assign v_o           = v_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign video_on_o    = video_q;
    assign frame_start_o = fstart_q;

endmodule

// File: rtl/hack_vga_scanout.sv
// Hack screen scan-out: fetches 16-bit words from screen RAM and serializes
// them LSB-first into a centred monochrome window on 640x480 VGA.
module hack_vga_scanout
    import hack_vga_pkg::*;
#(
    parameter int unsigned H_VIS  = DEF_H_VIS,
    parameter int unsigned H_FP   = DEF_H_FP,
    parameter int unsigned H_SYNC = DEF_H_SYNC,
    parameter int unsigned H_BP   = DEF_H_BP,
    parameter int unsigned V_VIS  = DEF_V_VIS,
    parameter int unsigned V_FP   = DEF_V_FP,
    parameter int unsigned V_SYNC = DEF_V_SYNC,
    parameter int unsigned V_BP   = DEF_V_BP,
    parameter int unsigned WIN_X0 = DEF_WIN_X0,
    parameter int unsigned WIN_Y0 = DEF_WIN_Y0,
    parameter int unsigned WIN_W  = DEF_WIN_W,
    parameter int unsigned WIN_H  = DEF_WIN_H
) (
    input  logic              clk50,
    input  logic              rst,
    output logic [ADDR_W-1:0] screen_addr,
    input  logic [WORD_W-1:0] screen_data,
    output logic              hsync,
    output logic              vsync,
    output logic              video_on,
    output logic              pixel,
    output logic              frame_start
);

    localparam cnt_t WX0    = cnt_t'(WIN_X0);
    localparam cnt_t WX_END = cnt_t'(WIN_X0 + WIN_W - 1);
    localparam cnt_t WY0    = cnt_t'(WIN_Y0);
    localparam cnt_t WY_END = cnt_t'(WIN_Y0 + WIN_H - 1);
    localparam cnt_t FX0    = cnt_t'(WIN_X0 - FETCH_LEAD);
    localparam cnt_t FX_END = cnt_t'(WIN_X0 - FETCH_LEAD + WIN_W - 1);
    localparam cnt_t LX0    = cnt_t'(WIN_X0 - LATCH_LEAD);
    localparam cnt_t LX_END = cnt_t'(WIN_X0 - LATCH_LEAD + WIN_W - 1);

    logic tick;
    cnt_t h, v;

    vga_sync_counter #(
        .H_VISIBLE    (H_VIS),
        .H_TOTAL      (H_VIS + H_FP + H_SYNC + H_BP),
        .H_SYNC_START (H_VIS + H_FP),
        .H_SYNC_END   (H_VIS + H_FP + H_SYNC - 1),
        .V_VISIBLE    (V_VIS),
        .V_TOTAL      (V_VIS + V_FP + V_SYNC + V_BP),
        .V_SYNC_START (V_VIS + V_FP),
        .V_SYNC_END   (V_VIS + V_FP + V_SYNC - 1)
    ) u_sync (
        .clk50_i       (clk50),
        .rst_i         (rst),
        .tick_o        (tick),
        .h_o           (h),
        .v_o           (v),
        .hsync_o       (hsync),
        .vsync_o       (vsync),
        .video_on_o    (video_on),
        .frame_start_o (frame_start)
    );

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] fbuf_q, fbuf_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              pixel_q, pixel_d;

    logic       win_row, win_col, fetch_hit, latch_hit;
    cnt_t       row, fetch_off;
    logic [3:0] latch_ph, col_ph;

    always_ff @(posedge clk50) begin
        if (rst) begin
            addr_q  <= '0;
            fbuf_q  <= '0;
            shreg_q <= '0;
            pixel_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            fbuf_q  <= fbuf_d;
            shreg_q <= shreg_d;
            pixel_q <= pixel_d;
        end
    end

    always_comb begin
        win_row   = in_range(v, WY0, WY_END);
        win_col   = in_range(h, WX0, WX_END);
        row       = v - WY0;
        fetch_off = h - FX0;
        latch_ph  = 4'(h - LX0);
        col_ph    = 4'(h - WX0);
        fetch_hit = win_row && in_range(h, FX0, FX_END) && (fetch_off[3:0] == 4'd0);
        latch_hit = win_row && in_range(h, LX0, LX_END) && (latch_ph == 4'd0);

        addr_d  = addr_q;
        fbuf_d  = fbuf_q;
        shreg_d = shreg_q;
        pixel_d = pixel_q;
        if (tick) begin
            if (fetch_hit) begin
                addr_d = ADDR_W'(32'(row) * WORDS_PER_ROW + 32'(fetch_off[CNT_W-1:4]));
            end
            if (latch_hit) begin
                fbuf_d = screen_data;
            end
            // Group boundary emits bit 0 straight from fetch_buf; the rest comes from the shifter.
            if (win_row && win_col) begin
                if (col_ph == 4'd0) begin
                    pixel_d = fbuf_q[0];
                    shreg_d = fbuf_q >> 1;
                end else begin
                    pixel_d = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end else begin
                pixel_d = 1'b0;
            end
        end
    end

    assign screen_addr = addr_q;
    assign pixel       = pixel_q;

endmodule

// File: tb/tb_hack_vga_scanout.sv
// Directed bench for hack_vga_scanout on a shortened 8-line frame (800-pixel
// lines kept), window rows v=1..2; edge counts are taken from reset release.
module tb_hack_vga_scanout;

    logic        clk50 = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] screen_addr;
    logic [15:0] screen_data;
    logic        hsync, vsync, video_on, pixel, frame_start;

    logic        ram_mode = 1'b0;
    logic [15:0] const_data = 16'h0000;
    logic [12:0] pipe [7];

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk50 = ~clk50;

    always @(posedge clk50) begin
        pipe[0] <= screen_addr;
        for (int i = 1; i < 7; i++) pipe[i] <= pipe[i-1];
    end

    assign screen_data = ram_mode ? {3'b000, pipe[6]} : const_data;

    hack_vga_scanout #(
        .V_VIS  (4),
        .V_FP   (1),
        .V_SYNC (2),
        .V_BP   (1),
        .WIN_Y0 (1),
        .WIN_H  (2)
    ) dut (
        .clk50       (clk50),
        .rst         (rst),
        .screen_addr (screen_addr),
        .screen_data (screen_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pixel       (pixel),
        .frame_start (frame_start)
    );

    task automatic step();
        @(posedge clk50);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_cmp++; if (hsync !== 1'b1) begin n_bad++; $display("FAIL reset_hsync: got %b want 1", hsync); end
        n_cmp++; if (vsync !== 1'b1) begin n_bad++; $display("FAIL reset_vsync: got %b want 1", vsync); end
        n_cmp++; if (video_on !== 1'b0) begin n_bad++; $display("FAIL reset_video_on: got %b want 0", video_on); end
        n_cmp++; if (pixel !== 1'b0) begin n_bad++; $display("FAIL reset_pixel: got %b want 0", pixel); end
        n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
        n_cmp++; if (screen_addr !== 13'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", screen_addr); end
    endtask

    task automatic test_timing();
        int hs_fall0, hs_fall1, hs_rise, vs_fall, vs_rise, fs0, fs1, fs_cnt;
        int vid_rise, vid_fall, vid_cnt, pix_cnt;
        logic hs_p, vs_p, vid_p;
        hs_fall0 = -1; hs_fall1 = -1; hs_rise = -1; vs_fall = -1; vs_rise = -1;
        fs0 = -1; fs1 = -1; fs_cnt = 0; vid_rise = -1; vid_fall = -1; vid_cnt = 0; pix_cnt = 0;
        hs_p = 1'b1; vs_p = 1'b1; vid_p = 1'b0;
        ram_mode = 1'b0;
        const_data = 16'h0000;
        do_reset();
        for (int e = 1; e <= 25610; e++) begin
            step();
            if (hs_p && !hsync) begin
                if (hs_fall0 < 0) hs_fall0 = e;
                else if (hs_fall1 < 0) hs_fall1 = e;
            end
            if (!hs_p && hsync && hs_rise < 0) hs_rise = e;
            if (vs_p && !vsync && vs_fall < 0) vs_fall = e;
            if (!vs_p && vsync && vs_rise < 0) vs_rise = e;
            if (!vid_p && video_on && vid_rise < 0) vid_rise = e;
            if (vid_p && !video_on && vid_fall < 0) vid_fall = e;
            if (frame_start) begin
                if (fs_cnt == 0) fs0 = e;
                if (fs_cnt == 1) fs1 = e;
                fs_cnt++;
            end
            if (e <= 12801 && video_on) vid_cnt++;
            if (pixel) pix_cnt++;
            hs_p = hsync; vs_p = vsync; vid_p = video_on;
        end
        n_cmp++; if (hs_fall0 !== 1314) begin n_bad++; $display("FAIL first_hsync_fall: got edge %0d want 1314", hs_fall0); end
        n_cmp++; if (hs_fall1 - hs_fall0 !== 1600) begin n_bad++; $display("FAIL line_period: got %0d want 1600", hs_fall1 - hs_fall0); end
        n_cmp++; if (hs_rise - hs_fall0 !== 192) begin n_bad++; $display("FAIL hsync_width: got %0d want 192", hs_rise - hs_fall0); end
        n_cmp++; if (vs_fall !== 8002) begin n_bad++; $display("FAIL vsync_fall: got edge %0d want 8002", vs_fall); end
        n_cmp++; if (vs_rise - vs_fall !== 3200) begin n_bad++; $display("FAIL vsync_width: got %0d want 3200", vs_rise - vs_fall); end
        n_cmp++; if (fs0 !== 12800) begin n_bad++; $display("FAIL first_frame_start: got edge %0d want 12800", fs0); end
        n_cmp++; if (fs1 - fs0 !== 12800) begin n_bad++; $display("FAIL frame_period: got %0d want 12800", fs1 - fs0); end
        n_cmp++; if (fs_cnt !== 2) begin n_bad++; $display("FAIL frame_start_cycles: got %0d want 2", fs_cnt); end
        n_cmp++; if (vid_rise !== 2) begin n_bad++; $display("FAIL video_rise: got edge %0d want 2", vid_rise); end
        n_cmp++; if (vid_fall !== 1282) begin n_bad++; $display("FAIL video_fall: got edge %0d want 1282", vid_fall); end
        n_cmp++; if (vid_cnt !== 5120) begin n_bad++; $display("FAIL video_cycles: got %0d want 5120", vid_cnt); end
        n_cmp++; if (pix_cnt !== 0) begin n_bad++; $display("FAIL pixels_zero_data: got %0d want 0", pix_cnt); end
    endtask

    // all_black=0 drives 16'h0001, all_black=1 drives 16'hFFFF.
    task automatic test_pattern(input bit all_black);
        int p, h, v, pix_bad, vid_bad, black, border_ones, blank_ones, exp_black;
        logic exp_vid, exp_pix, in_win;
        pix_bad = 0; vid_bad = 0; black = 0; border_ones = 0; blank_ones = 0;
        exp_black = all_black ? 1024 : 64;
        ram_mode = 1'b0;
        const_data = all_black ? 16'hFFFF : 16'h0001;
        do_reset();
        for (int e = 1; e <= 6410; e++) begin
            step();
            if (e % 2 == 0) begin
                p = e / 2 - 1;
                h = p % 800;
                v = (p / 800) % 8;
                exp_vid = (h < 640) && (v < 4);
                in_win = (v >= 1) && (v <= 2) && (h >= 64) && (h <= 575);
                exp_pix = in_win && (all_black || ((h - 64) % 16 == 0));
                if (video_on !== exp_vid) vid_bad++;
                if (pixel !== exp_pix) pix_bad++;
                if (pixel === 1'b1) black++;
                if (pixel === 1'b1 && (h < 64 || (h >= 576 && h < 640))) border_ones++;
                if (pixel === 1'b1 && video_on !== 1'b1) blank_ones++;
            end
        end
        n_cmp++; if (pix_bad !== 0) begin n_bad++; $display("FAIL pattern%0d_pixel: %0d wrong pixels, want 0", all_black, pix_bad); end
        n_cmp++; if (vid_bad !== 0) begin n_bad++; $display("FAIL pattern%0d_video_on: %0d wrong samples, want 0", all_black, vid_bad); end
        n_cmp++; if (black !== exp_black) begin n_bad++; $display("FAIL pattern%0d_black_count: got %0d want %0d", all_black, black, exp_black); end
        n_cmp++; if (border_ones !== 0) begin n_bad++; $display("FAIL pattern%0d_border: got %0d black border pixels want 0", all_black, border_ones); end
        n_cmp++; if (blank_ones !== 0) begin n_bad++; $display("FAIL pattern%0d_blank: got %0d black blanking pixels want 0", all_black, blank_ones); end
    endtask

    task automatic test_ram_model();
        int p, h, v, r, c, word, pix_bad, nchg, order_bad, first_chg;
        logic exp_pix;
        logic [12:0] last;
        pix_bad = 0; nchg = 0; order_bad = 0; first_chg = -1;
        ram_mode = 1'b1;
        do_reset();
        last = screen_addr;
        for (int e = 1; e <= 12810; e++) begin
            step();
            if (screen_addr !== last) begin
                nchg++;
                if (screen_addr !== last + 13'd1) order_bad++;
                if (first_chg < 0) first_chg = e;
                last = screen_addr;
            end
            if (e % 2 == 0) begin
                p = e / 2 - 1;
                h = p % 800;
                v = (p / 800) % 8;
                exp_pix = 1'b0;
                if (v >= 1 && v <= 2 && h >= 64 && h <= 575) begin
                    r = v - 1;
                    c = h - 64;
                    word = r * 32 + c / 16;
                    exp_pix = ((word >> (c % 16)) & 1) == 1;
                end
                if (pixel !== exp_pix) pix_bad++;
            end
        end
        n_cmp++; if (first_chg !== 1746) begin n_bad++; $display("FAIL ram_first_addr_change: got edge %0d want 1746", first_chg); end
        n_cmp++; if (nchg !== 63) begin n_bad++; $display("FAIL ram_addr_changes: got %0d want 63", nchg); end
        n_cmp++; if (order_bad !== 0) begin n_bad++; $display("FAIL ram_addr_order: got %0d out-of-order want 0", order_bad); end
        n_cmp++; if (screen_addr !== 13'd63) begin n_bad++; $display("FAIL ram_last_addr: got %0d want 63", screen_addr); end
        n_cmp++; if (pix_bad !== 0) begin n_bad++; $display("FAIL ram_pixel_bits: %0d wrong pixels, want 0", pix_bad); end
        ram_mode = 1'b0;
    endtask

    task automatic test_reset_midline();
        int hs_fall, fs_edge;
        logic hs_p, vid1, vid2;
        hs_fall = -1; fs_edge = -1; hs_p = 1'b1; vid1 = 1'bx; vid2 = 1'bx;
        ram_mode = 1'b0;
        const_data = 16'hFFFF;
        do_reset();
        repeat (3801) step();
        n_cmp++; if (pixel !== 1'b1) begin n_bad++; $display("FAIL midline_pixel_before: got %b want 1", pixel); end
        n_cmp++; if (screen_addr !== 13'd47) begin n_bad++; $display("FAIL midline_addr_before: got %0d want 47", screen_addr); end
        rst = 1'b1;
        step();
        n_cmp++; if (hsync !== 1'b1) begin n_bad++; $display("FAIL midline_hsync: got %b want 1", hsync); end
        n_cmp++; if (vsync !== 1'b1) begin n_bad++; $display("FAIL midline_vsync: got %b want 1", vsync); end
        n_cmp++; if (video_on !== 1'b0) begin n_bad++; $display("FAIL midline_video_on: got %b want 0", video_on); end
        n_cmp++; if (pixel !== 1'b0) begin n_bad++; $display("FAIL midline_pixel: got %b want 0", pixel); end
        n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL midline_frame_start: got %b want 0", frame_start); end
        n_cmp++; if (screen_addr !== 13'd0) begin n_bad++; $display("FAIL midline_addr: got %0d want 0", screen_addr); end
        step();
        step();
        rst = 1'b0;
        for (int e = 1; e <= 12801; e++) begin
            step();
            if (e == 1) vid1 = video_on;
            if (e == 2) vid2 = video_on;
            if (hs_p && !hsync && hs_fall < 0) hs_fall = e;
            if (frame_start && fs_edge < 0) fs_edge = e;
            hs_p = hsync;
        end
        n_cmp++; if (vid1 !== 1'b0 || vid2 !== 1'b1) begin n_bad++; $display("FAIL midline_restart_video: got %b%b want 01", vid1, vid2); end
        n_cmp++; if (hs_fall !== 1314) begin n_bad++; $display("FAIL midline_first_hsync: got edge %0d want 1314", hs_fall); end
        n_cmp++; if (fs_edge !== 12800) begin n_bad++; $display("FAIL midline_frame_start_edge: got edge %0d want 12800", fs_edge); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_pattern(1'b0);
        test_pattern(1'b1);
        test_ram_model();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hack_vga_scanout.md
# hack_vga_scanout

Scan-out engine for the Hack screen. It runs on the 50 MHz system clock and generates 640x480@60 VGA timing from an internal 25 MHz pixel enable, so the design uses a single clock rather than a divided one. It fetches 16-bit words from the 8K-word Hack screen memory and serializes them as a centred 512x256 monochrome window. It sits between the screen RAM read port and the VGA connector pins.

## Interface
Parameters:
- H_VIS 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal pixels (total 800).
- V_VIS 480, V_FP 10, V_SYNC 2, V_BP 33: vertical lines (total 525).
- WIN_X0 64, WIN_Y0 112: top-left of the Hack window in visible coordinates.
- WIN_W 512, WIN_H 256: Hack window size; WIN_W is a multiple of 16.

Ports:
- clk50 in 1: system clock, 50 MHz.
- rst in 1: synchronous, active-high reset.
- screen_addr out 13: word address into screen RAM; registered.
- screen_data in 16: RAM read data, valid no later than 7 clk50 cycles after screen_addr changes.
- hsync out 1: active-low horizontal sync.
- vsync out 1: active-low vertical sync.
- video_on out 1: high during the 640x480 visible region.
- pixel out 1: Hack pixel; 1 = black, 0 = white/border/blanking.
- frame_start out 1: one-clk50 pulse at frame origin.

## Operation
- Pixel enable tick: a toggle that resets to 0 and inverts every clk50 cycle. A tick is any cycle in which the toggle is 1, so a tick occurs every 2nd cycle; the first tick falls on the 2nd cycle after rst deasserts.
- Counters h (10 bit, 0..799) and v (10 bit, 0..524) advance only on ticks.
  - h wraps 799->0 and increments v.
  - v wraps 524->0 when h wraps.
- Sync decode:
  - hsync is low for h in [656,751].
  - vsync is low for v in [490,491].
  - video_on is high for h<640 and v<480.
- Window: h in [WIN_X0, WIN_X0+511] and v in [WIN_Y0, WIN_Y0+255]. Hack row r = v-WIN_Y0, column c = h-WIN_X0.
- Mapping: word address = r*32 + c/16; bit index = c%16. Bit 0 is the leftmost pixel of its group.
- Fetch sequence for group k=0..31, on window rows only:
  - At the tick where h == WIN_X0+16k-8, screen_addr <= r*32+k.
  - At the tick where h == WIN_X0+16k-4, fetch_buf <= screen_data.
  - At h == WIN_X0+16k, the output emits fetch_buf[0] and the shift register loads fetch_buf>>1. The following 15 ticks emit successive bits.
- Outside the window, pixel = 0. Outside the visible region, pixel = 0 and video_on = 0.
- screen_addr holds its last value between fetches. On non-window rows no fetch occurs.

## Timing
- Output registers: hsync, vsync, video_on and pixel for counter position (h,v) update on the tick edge that advances the counter out of (h,v). Latency is one pixel (2 clk50) and identical for all four outputs, so they remain mutually aligned.
- frame_start is high for exactly the one clk50 cycle following the tick edge where (h,v) wraps to (0,0).
- Line period is 1600 clk50 cycles; frame period is 840000 clk50 cycles.
- Reset values: h=0, v=0, toggle=0, hsync=1, vsync=1, video_on=0, pixel=0, frame_start=0, screen_addr=0, fetch_buf=0, shift register=0.
- Reset mid-frame: all state returns to the reset values on the next edge. No partial line is completed, and scan-out restarts at (0,0).
- The first fetch of each window row (k=0) occurs at h=WIN_X0-8, inside the left border. No fetch is ever issued for k=32.
- The last word of a frame is at address 8191 (r=255, k=31). The address never exceeds 8191.

## Structure
- Shared package hack_vga_pkg holds:
  - the VGA timing constants and derived totals/sync start and end values;
  - the window origin and size;
  - SCREEN_WORDS = 8192 and WORDS_PER_ROW = 32.
- Sub-module vga_sync_counter holds the tick toggle, the h/v counters, the sync/video_on decode and frame_start. It exports h, v, tick and the registered syncs.
- The top level holds fetch addressing, fetch_buf, the shift register and pixel output.

## Test plan
- Reset release, screen_data=0: hsync falling edges 1600 clk50 apart; hsync low 192 cycles; vsync low 3200 cycles; frame_start pulses 840000 cycles apart.
- screen_data=16'h0001: pixel=1 exactly at visible x = 64, 80, …, 560 on rows 112..367, and 0 elsewhere; 32*256=8192 black pixels per frame.
- RAM model returning data = address with 7-cycle latency: screen_addr sequence per row r is r*32..r*32+31; frame ends at 8191; the serialized pixel bits equal the address bits LSB-first.
- screen_data=16'hFFFF: 131072 black pixels per frame; pixel=0 whenever video_on=0; border columns 0..63 and 576..639 are all 0.
- Assert rst for 3 cycles mid-line (h≈300, v≈200): all outputs take their reset values the next cycle. The first hsync falls 656*2+2 clk50 cycles after release, and the next frame_start occurs 840000 cycles after release.
